// File: rtl/light_bar_monitor_if.sv
// ---------------------------------------------------------------------------
// light_bar_monitor_if
// Bundles the observed lamp bus, the counter clear and every decoded status
// output of light_bar_monitor.
//   master : the side that drives the bus and clear, and reads status
//            (flasher top level or bench)
//   slave  : the monitor itself
// Signals:
//   clr         synchronous clear of counters and sticky error
//   light       lamp bus under observation (WIDTH lamps)
//   level       decoded lamp count 0..WIDTH
//   state       sweep state: 0=IDLE, 1=UP, 2=DOWN
//   turn_pulse  one-cycle pulse on a direction reversal
//   turn_level  level at the last reversal (peak or valley)
//   done_pulse  one-cycle pulse when a DOWN sweep reaches level 0
//   sweep_cnt   completed sweeps, saturating
//   err_shape   one-cycle pulse: bus is not a thermometer code
//   err_step    one-cycle pulse: level moved by more than one lamp
//   err_cnt     total error cycles, saturating
//   err_sticky  set on any error, cleared by reset or clr
// ---------------------------------------------------------------------------
interface light_bar_monitor_if #(
   parameter int WIDTH = 16,
   parameter int LVL_W = 5,
   parameter int CNT_W = 8
);
   logic             clr;
   logic [WIDTH-1:0] light;
   logic [LVL_W-1:0] level;
   logic [1:0]       state;
   logic             turn_pulse;
   logic [LVL_W-1:0] turn_level;
   logic             done_pulse;
   logic [CNT_W-1:0] sweep_cnt;
   logic             err_shape;
   logic             err_step;
   logic [CNT_W-1:0] err_cnt;
   logic             err_sticky;

   modport master (
      output clr, light,
      input  level, state, turn_pulse, turn_level, done_pulse, sweep_cnt,
             err_shape, err_step, err_cnt, err_sticky
   );

   modport slave (
      input  clr, light,
      output level, state, turn_pulse, turn_level, done_pulse, sweep_cnt,
             err_shape, err_step, err_cnt, err_sticky
   );
endinterface

// File: rtl/light_bar_monitor.sv
// ---------------------------------------------------------------------------
// light_bar_monitor
// Receive-side checker for the thermometer-coded lamp bus of the flasher.
// Each clock the bus is decoded to a lamp count and tracked through an
// IDLE/UP/DOWN sweep machine. Reversals, completed sweeps, malformed codes
// and multi-lamp jumps are flagged; sweeps and errors are counted.
// All outputs are registered and reflect the sample taken at the same edge.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      light_bar_monitor_if.slave (clr, light in; status out)
// ---------------------------------------------------------------------------
module light_bar_monitor #(
   parameter int WIDTH = 16,
   parameter int LVL_W = 5,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   light_bar_monitor_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } sweep_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Registered state and outputs
   sweep_e           state_q;
   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] turn_level_q;
   logic             turn_pulse_q;
   logic             done_pulse_q;
   logic [CNT_W-1:0] sweep_cnt_q;
   logic             err_shape_q;
   logic             err_step_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic             err_sticky_q;

   // Decode of the current sample
   logic [WIDTH-1:0] light_inc;
   logic [LVL_W-1:0] new_lvl;
   logic             valid;
   logic             hold;
   logic             step_up;
   logic             step_dn;
   logic             jump;
   logic             err_now;
   logic             done_now;

   assign light_inc = bus.light + 1'b1;

   always_comb begin
      // NOTE: every signal gets a default before any conditional logic, so
      // no path can leave it unassigned and infer a latch.
      new_lvl  = '0;
      valid    = 1'b0;
      hold     = 1'b0;
      step_up  = 1'b0;
      step_dn  = 1'b0;
      jump     = 1'b0;
      err_now  = 1'b0;
      done_now = 1'b0;

      for (int i = 0; i < WIDTH; i++) begin
         new_lvl = new_lvl + LVL_W'(bus.light[i]);
      end

      // A thermometer code 2^n-1 has no set bit in common with itself + 1
      // (all-ones wraps to zero, which also passes).
      valid   = (bus.light & light_inc) == '0;
      hold    = valid && (new_lvl == level_q);
      step_up = valid && (new_lvl == LVL_W'(level_q + 1'b1));
      step_dn = valid && (LVL_W'(new_lvl + 1'b1) == level_q);
      jump    = valid && !hold && !step_up && !step_dn;

      // Shape and step errors are mutually exclusive: jump requires valid.
      err_now  = !valid || jump;
      done_now = step_dn && (new_lvl == '0) && (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         level_q      <= '0;
         turn_level_q <= '0;
         turn_pulse_q <= 1'b0;
         done_pulse_q <= 1'b0;
         sweep_cnt_q  <= '0;
         err_shape_q  <= 1'b0;
         err_step_q   <= 1'b0;
         err_cnt_q    <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the values from before this edge regardless of order.
         turn_pulse_q <= 1'b0;
         done_pulse_q <= done_now;
         err_shape_q  <= !valid;
         err_step_q   <= jump;

         if (jump) begin
            // Resync to the new level without claiming a reversal or sweep.
            level_q <= new_lvl;
            if (new_lvl == '0)
               state_q <= IDLE;
            else if (new_lvl > level_q)
               state_q <= UP;
            else
               state_q <= DOWN;
         end else if (step_up) begin
            level_q <= new_lvl;
            state_q <= UP;
            if (state_q == DOWN) begin
               turn_pulse_q <= 1'b1;
               turn_level_q <= level_q;
            end
         end else if (step_dn) begin
            level_q <= new_lvl;
            state_q <= (new_lvl == '0) ? IDLE : DOWN;
            // Includes the 1 -> 0 step from UP, which is both a peak and the
            // end of a sweep.
            if (state_q == UP) begin
               turn_pulse_q <= 1'b1;
               turn_level_q <= level_q;
            end
         end

         // Counters and sticky flag: clr wins over a same-cycle event.
         if (bus.clr)
            sweep_cnt_q <= '0;
         else if (done_now && sweep_cnt_q != CNT_MAX)
            sweep_cnt_q <= sweep_cnt_q + 1'b1;

         if (bus.clr)
            err_cnt_q <= '0;
         else if (err_now && err_cnt_q != CNT_MAX)
            err_cnt_q <= err_cnt_q + 1'b1;

         if (bus.clr)
            err_sticky_q <= 1'b0;
         else if (err_now)
            err_sticky_q <= 1'b1;
      end
   end

   assign bus.level      = level_q;
   assign bus.state      = state_q;
   assign bus.turn_pulse = turn_pulse_q;
   assign bus.turn_level = turn_level_q;
   assign bus.done_pulse = done_pulse_q;
   assign bus.sweep_cnt  = sweep_cnt_q;
   assign bus.err_shape  = err_shape_q;
   assign bus.err_step   = err_step_q;
   assign bus.err_cnt    = err_cnt_q;
   assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_light_bar_monitor.sv
// ---------------------------------------------------------------------------
// tb_light_bar_monitor
// Self-checking bench for light_bar_monitor: a table of {bus, clr, expected
// status} records applied through a scoreboard queue, followed by hand
// sequences for counter saturation with clr and an asynchronous mid-sweep
// reset.
// ---------------------------------------------------------------------------
module tb_light_bar_monitor;

   localparam int WIDTH = 16;
   localparam int LVL_W = 5;
   localparam int CNT_W = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_UP   = 2'd1;
   localparam logic [1:0] S_DOWN = 2'd2;

   typedef struct packed {
      logic [LVL_W-1:0] level;
      logic [1:0]       state;
      logic             turn_pulse;
      logic [LVL_W-1:0] turn_level;
      logic             done_pulse;
      logic [CNT_W-1:0] sweep_cnt;
      logic             err_shape;
      logic             err_step;
      logic [CNT_W-1:0] err_cnt;
      logic             err_sticky;
   } obs_t;

   typedef struct {
      logic [WIDTH-1:0] light;
      logic             clr;
      obs_t             exp;
   } vec_t;

   logic clk;
   logic reset_n;

   int n_pass;
   int n_total;

   vec_t vecs[$];
   obs_t sb[$];

   light_bar_monitor_if #(.WIDTH(WIDTH), .LVL_W(LVL_W), .CNT_W(CNT_W)) bus ();

   light_bar_monitor #(.WIDTH(WIDTH), .LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] th(input int n);
      logic [31:0] v;
      v = (32'd1 << n) - 32'd1;
      return v[WIDTH-1:0];
   endfunction

   function automatic obs_t mk(input int lvl, input logic [1:0] st, input logic tp,
                               input int tl, input logic dp, input int sc,
                               input logic sh, input logic sp, input int ec,
                               input logic stk);
      obs_t o;
      o.level      = LVL_W'(lvl);
      o.state      = st;
      o.turn_pulse = tp;
      o.turn_level = LVL_W'(tl);
      o.done_pulse = dp;
      o.sweep_cnt  = CNT_W'(sc);
      o.err_shape  = sh;
      o.err_step   = sp;
      o.err_cnt    = CNT_W'(ec);
      o.err_sticky = stk;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.level      = bus.level;
      o.state      = bus.state;
      o.turn_pulse = bus.turn_pulse;
      o.turn_level = bus.turn_level;
      o.done_pulse = bus.done_pulse;
      o.sweep_cnt  = bus.sweep_cnt;
      o.err_shape  = bus.err_shape;
      o.err_step   = bus.err_step;
      o.err_cnt    = bus.err_cnt;
      o.err_sticky = bus.err_sticky;
      return o;
   endfunction

   task automatic add(input logic [WIDTH-1:0] light, input logic clr, input obs_t exp);
      vec_t v;
      v.light = light;
      v.clr   = clr;
      v.exp   = exp;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got lvl=%0d st=%0d tp=%0d tl=%0d dp=%0d sc=%0d sh=%0d sp=%0d ec=%0d stk=%0d | want lvl=%0d st=%0d tp=%0d tl=%0d dp=%0d sc=%0d sh=%0d sp=%0d ec=%0d stk=%0d",
                  name, act.level, act.state, act.turn_pulse, act.turn_level, act.done_pulse,
                  act.sweep_cnt, act.err_shape, act.err_step, act.err_cnt, act.err_sticky,
                  exp.level, exp.state, exp.turn_pulse, exp.turn_level, exp.done_pulse,
                  exp.sweep_cnt, exp.err_shape, exp.err_step, exp.err_cnt, exp.err_sticky);
      end
   endtask

   // Drive one sample before the edge, queue its expectation, then compare
   // against what the DUT shows just after the edge.
   task automatic apply(input vec_t v, input string name);
      obs_t e;
      @(negedge clk);
      bus.light = v.light;
      bus.clr   = v.clr;
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         check(name, sample(), e);
      end
   endtask

   initial begin
      vec_t v;
      int   ec;

      n_pass    = 0;
      n_total   = 0;
      reset_n   = 1'b0;
      bus.clr   = 1'b0;
      bus.light = '0;

      // ---------------- vector table ----------------
      // Ramp 0 -> 5 -> 0
      add(16'h0000, 1'b0, mk(0, S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int n = 1; n <= 5; n++)
         add(th(n), 1'b0, mk(n, S_UP, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int n = 4; n >= 1; n--)
         add(th(n), 1'b0, mk(n, S_DOWN, n == 4, 5, 0, 0, 0, 0, 0, 0));
      add(16'h0000, 1'b0, mk(0, S_IDLE, 0, 5, 1, 1, 0, 0, 0, 0));
      // Ramp to 10, fall to 5, rise to 16
      for (int n = 1; n <= 10; n++)
         add(th(n), 1'b0, mk(n, S_UP, 0, 5, 0, 1, 0, 0, 0, 0));
      for (int n = 9; n >= 5; n--)
         add(th(n), 1'b0, mk(n, S_DOWN, n == 9, 10, 0, 1, 0, 0, 0, 0));
      for (int n = 6; n <= 16; n++)
         add(th(n), 1'b0, mk(n, S_UP, n == 6, 5, 0, 1, 0, 0, 0, 0));
      // Jump 16 -> 0: step error straight to IDLE, no sweep counted
      add(16'h0000, 1'b0, mk(0, S_IDLE, 0, 5, 0, 1, 0, 1, 1, 1));
      // clr clears counters and sticky, keeps turn_level
      add(16'h0000, 1'b1, mk(0, S_IDLE, 0, 5, 0, 0, 0, 0, 0, 0));
      // Shape error at level 3
      for (int n = 1; n <= 3; n++)
         add(th(n), 1'b0, mk(n, S_UP, 0, 5, 0, 0, 0, 0, 0, 0));
      add(16'h0005, 1'b0, mk(3, S_UP, 0, 5, 0, 0, 1, 0, 1, 1));
      add(16'h0007, 1'b0, mk(3, S_UP, 0, 5, 0, 0, 0, 0, 1, 1));
      // Peak at 3, then jump 2 -> 8 upward and 8 -> 1 downward
      add(16'h0003, 1'b0, mk(2, S_DOWN, 1, 3, 0, 0, 0, 0, 1, 1));
      add(16'h00FF, 1'b0, mk(8, S_UP, 0, 3, 0, 0, 0, 1, 2, 1));
      add(16'h0001, 1'b0, mk(1, S_DOWN, 0, 3, 0, 0, 0, 1, 3, 1));
      add(16'h0000, 1'b0, mk(0, S_IDLE, 0, 3, 1, 1, 0, 0, 3, 1));
      // 1 -> 0 while UP: reversal plus completed sweep
      add(16'h0001, 1'b0, mk(1, S_UP, 0, 3, 0, 1, 0, 0, 3, 1));
      add(16'h0000, 1'b0, mk(0, S_IDLE, 1, 1, 1, 2, 0, 0, 3, 1));

      // ---------------- reset state ----------------
      #12;
      check("reset_state", sample(), obs_t'(0));
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], $sformatf("vec%0d", i));

      // ---------------- saturation, then clr with an error ----------------
      ec = 3;
      for (int i = 0; i < 260; i++) begin
         ec = (ec < 255) ? ec + 1 : 255;
         v.light = 16'h0005;
         v.clr   = 1'b0;
         v.exp   = mk(0, S_IDLE, 0, 1, 0, 2, 1, 0, ec, 1);
         apply(v, $sformatf("sat%0d", i));
      end
      v.light = 16'h0005;
      v.clr   = 1'b1;
      v.exp   = mk(0, S_IDLE, 0, 1, 0, 0, 1, 0, 0, 0);
      apply(v, "clr_with_err");
      v.light = 16'h0000;
      v.clr   = 1'b0;
      v.exp   = mk(0, S_IDLE, 0, 1, 0, 0, 0, 0, 0, 0);
      apply(v, "after_clr");

      // ---------------- async reset mid-sweep ----------------
      for (int n = 1; n <= 7; n++) begin
         v.light = th(n);
         v.clr   = 1'b0;
         v.exp   = mk(n, S_UP, 0, 1, 0, 0, 0, 0, 0, 0);
         apply(v, $sformatf("pre_rst%0d", n));
      end
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", sample(), obs_t'(0));
      bus.light = '0;
      @(negedge clk);
      reset_n = 1'b1;
      v.light = 16'h007F;
      v.clr   = 1'b0;
      v.exp   = mk(7, S_UP, 0, 0, 0, 0, 0, 1, 1, 1);
      apply(v, "post_rst_jump");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
